// File: rtl/lz77_encoder.sv
// rtl/lz77_encoder.sv - streaming LZ77 compressor, 9-entry search / 8-entry look-ahead
// Emits (pos, len, char) tokens; stream ends with the token carrying '$'.
module lz77_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [7:0] chardata,
  output logic       char_ready,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [3:0] code_pos,
  output logic [2:0] code_len,
  output logic [7:0] code_char,
  output logic       finish
);

  typedef enum logic [2:0] {FILL, SEARCH, EMIT, SHIFT, DONE} state_t;

  localparam logic [7:0] EOS = 8'h24;

  state_t     state_q;
  logic [7:0] sb_q [0:8];
  logic [7:0] la_q [0:7];
  logic [3:0] la_cnt_q;
  logic       eos_q;
  logic [3:0] p_q;
  logic [2:0] best_len_q;
  logic [3:0] best_pos_q;
  logic [3:0] shift_cnt_q;
  logic       code_valid_q;
  logic [3:0] code_pos_q;
  logic [2:0] code_len_q;
  logic [7:0] code_char_q;
  logic       finish_q;

  logic       accept;
  logic [2:0] wr_idx;
  logic [3:0] la_cnt_d;
  logic [2:0] max_len;
  logic [2:0] cur_len;
  logic       run;
  logic [7:0] src;
  logic [2:0] fin_len;
  logic [3:0] fin_pos;

  assign char_ready = !reset && (state_q == FILL || state_q == SHIFT) &&
                      (la_cnt_q < 4'd8) && !eos_q;
  assign accept     = char_valid && char_ready;
  assign code_valid = code_valid_q;
  assign code_pos   = code_pos_q;
  assign code_len   = code_len_q;
  assign code_char  = code_char_q;
  assign finish     = finish_q;

  // During SHIFT the new character lands one slot lower, after the shift.
  always_comb begin
    wr_idx   = 3'(la_cnt_q);
    la_cnt_d = la_cnt_q + {3'b000, accept};
    if (state_q == SHIFT) begin
      wr_idx   = 3'(la_cnt_q - 4'd1);
      la_cnt_d = la_cnt_q - 4'd1 + {3'b000, accept};
    end
  end

  // Match length of candidate p_q; sources past sb[0] run into la, allowing overlap.
  always_comb begin
    max_len = 3'd0;
    if (la_cnt_q >= 4'd8)
      max_len = 3'd7;
    else if (la_cnt_q != 4'd0)
      max_len = 3'(la_cnt_q - 4'd1);
    cur_len = 3'd0;
    run     = 1'b1;
    src     = 8'h00;
    for (int j = 0; j < 7; j++) begin
      if (4'(j) <= p_q)
        src = sb_q[p_q - 4'(j)];
      else
        src = la_q[3'(4'(j) - p_q - 4'd1)];
      if (run && (3'(j) < max_len) && (la_q[3'(j)] == src))
        cur_len = 3'(j + 1);
      else
        run = 1'b0;
    end
  end

  always_comb begin
    fin_len = best_len_q;
    fin_pos = best_pos_q;
    if (cur_len > best_len_q) begin
      fin_len = cur_len;
      fin_pos = p_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FILL;
      for (int k = 0; k < 9; k++) sb_q[k] <= 8'h00;
      for (int k = 0; k < 8; k++) la_q[k] <= 8'h00;
      la_cnt_q     <= 4'd0;
      eos_q        <= 1'b0;
      p_q          <= 4'd0;
      best_len_q   <= 3'd0;
      best_pos_q   <= 4'd0;
      shift_cnt_q  <= 4'd0;
      code_valid_q <= 1'b0;
      code_pos_q   <= 4'd0;
      code_len_q   <= 3'd0;
      code_char_q  <= 8'h00;
      finish_q     <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          best_len_q <= 3'd0;
          best_pos_q <= 4'd0;
          p_q        <= 4'd0;
          if (la_cnt_q == 4'd8 || (eos_q && la_cnt_q != 4'd0))
            state_q <= SEARCH;
        end
        SEARCH: begin
          best_len_q <= fin_len;
          best_pos_q <= fin_pos;
          if (p_q == 4'd8) begin
            state_q      <= EMIT;
            code_valid_q <= 1'b1;
            code_len_q   <= fin_len;
            code_pos_q   <= (fin_len == 3'd0) ? 4'd0 : fin_pos;
            code_char_q  <= la_q[fin_len];
          end else begin
            p_q <= p_q + 4'd1;
          end
        end
        EMIT: begin
          if (code_ready) begin
            code_valid_q <= 1'b0;
            code_pos_q   <= 4'd0;
            code_len_q   <= 3'd0;
            code_char_q  <= 8'h00;
            if (code_char_q == EOS) begin
              state_q  <= DONE;
              finish_q <= 1'b1;
            end else begin
              state_q     <= SHIFT;
              shift_cnt_q <= {1'b0, best_len_q} + 4'd1;
            end
          end
        end
        SHIFT: begin
          sb_q[0] <= la_q[0];
          for (int k = 1; k < 9; k++) sb_q[k] <= sb_q[k-1];
          for (int k = 0; k < 7; k++) la_q[k] <= la_q[k+1];
          shift_cnt_q <= shift_cnt_q - 4'd1;
          if (shift_cnt_q == 4'd1)
            state_q <= FILL;
        end
        DONE: begin
          state_q <= DONE;
        end
        default: state_q <= FILL;
      endcase

      la_cnt_q <= (state_q == SHIFT || accept) ? la_cnt_d : la_cnt_q;
      if (accept) begin
        la_q[wr_idx] <= chardata;
        if (chardata == EOS)
          eos_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/lz77_encoder.md
# lz77_encoder

Streaming LZ77 compressor, the transmit-side counterpart of the in-house LZ77 decoder. It accepts one 8-bit character per handshake and emits `(code_pos, code_len, code_char)` tokens. The decoder reconstructs the stream exactly from these tokens. It uses a 9-entry search buffer and an 8-entry look-ahead buffer, and the stream is terminated by `'$'` (8'h24).

## Interface

Parameters: none. Sizes are fixed at search buffer 9, look-ahead 8, maximum match 7.

- `clk`  input  1  clock, rising edge.
- `reset`  input  1  reset, asynchronous, active-high.
- `char_valid`  input  1  `chardata` carries a valid character.
- `chardata`  input  8  input character.
- `char_ready`  output  1  encoder accepts `chardata` this cycle.
- `code_valid`  output  1  token outputs are valid.
- `code_ready`  input  1  downstream accepts the token.
- `code_pos`  output  4  match distance minus 1 (0..8).
- `code_len`  output  3  match length (0..7).
- `code_char`  output  8  literal character following the match.
- `finish`  output  1  the `'$'`-bearing token has been accepted. Sticky.

## Operation

**Storage**
- `sb[0..8]` is the search buffer; `sb[0]` is the newest character.
- `la[0..7]` is the look-ahead buffer, plus `la_cnt` (0..8).
- `eos_seen` flag.
- Reset value of all storage, and of `la_cnt` and `eos_seen`: 0.
- Matches against reset-zero `sb` entries are legal, because the decoder resets identically.

**Input acceptance**
- `char_ready` = (state is FILL or SHIFT) && `la_cnt` < 8 && !`eos_seen`.
- On a transfer, the character is written to `la[la_cnt]`.
- A `'$'` transfer sets `eos_seen`.

**Match source**
- For candidate p and offset j: `src(p,j)` = `sb[p-j]` if j ≤ p, else `la[j-p-1]`. Overlapping copies are therefore allowed.
- `L(p)` = the largest L ≤ min(7, `la_cnt`-1) such that `la[j]` == `src(p,j)` for all j < L.

**FSM**
- **FILL**
  - Go to SEARCH when `la_cnt` == 8, or when `eos_seen` && `la_cnt` ≥ 1.
  - Clear `best_len` and `best_pos`.
- **SEARCH**
  - Counter p runs 0..8, one candidate per cycle.
  - Update the best candidate only if `L(p)` > `best_len` (strict), so ties keep the smallest p.
  - After p = 8, go to EMIT.
- **EMIT**
  - Drive `code_valid`=1, `code_pos`=`best_pos`, `code_len`=`best_len`, `code_char`=`la[best_len]`.
  - If `best_len`==0, `code_pos` is forced to 0, giving the literal token (0,0,c).
  - Outputs are held stable until `code_ready`.
  - On accept: if `code_char`==`'$'`, go to DONE; else go to SHIFT with `shift_cnt` = `best_len`+1.
- **SHIFT**
  - Each cycle: `sb[k]`←`sb[k-1]`, `sb[0]`←`la[0]`, `la[k]`←`la[k+1]`, `la_cnt`−1, `shift_cnt`−1.
  - A same-cycle input write lands at `la[la_cnt-1]`, i.e. after the shift, and the counts net out.
  - When `shift_cnt` reaches 1 on this cycle, go to FILL.
- **DONE**
  - `finish`=1, `char_ready`=0, `code_valid`=0.
  - Stay until reset.

**Boundaries**
- `la_cnt`-1 bounds the match length, so `code_char` always exists.
- `'$'` is never included in a match; it is always `code_char`.
- Characters after `'$'` are not accepted.
- Reset mid-token aborts the token. All outputs go low and the FSM returns to FILL with empty buffers.

## Timing

- Reset values:
  - `char_ready`=0 while reset is asserted, then 1 in FILL.
  - `code_valid`=0, `code_pos`=0, `code_len`=0, `code_char`=0, `finish`=0.
- All outputs are registered or decoded from state. There is no combinational path from `code_ready` to `code_valid`.
- Per-token latency:
  - FILL exit → `code_valid` high takes 9 SEARCH cycles, plus 1 cycle to enter EMIT.
  - SHIFT takes `code_len`+1 cycles.
  - Steady state, with input always valid and output always ready: 11 + `code_len` cycles per token, plus refill cycles.
- `finish` rises the cycle after the `'$'` token handshake.
- `code_valid` and `char_ready` are never high in the same cycle.

## Test plan

1. **Overlapping match.** Reset, then stream "AAAA$".
   - Required tokens: (0,0,'A'), then (0,3,'$').
   - `finish`=1 one cycle after the second accept.
2. **Match and literal.** Stream "ABCABC$".
   - Required tokens: (0,0,'A'), (0,0,'B'), (0,0,'C'), (2,3,'$').
3. **Maximum length cap.** Stream "A" followed by nine "A"s, then "$".
   - Required tokens: (0,0,'A'), (0,7,'A'), (0,1,'$').
4. **Tie-break and reset-zero match.** Stream 8'h00, 8'h00, '$'.
   - Required tokens: (0,2,'$'). The zero history matches, and p=0 wins the tie.
5. **Backpressure.** Hold `code_ready`=0 for 20 cycles during the first token of test 2.
   - `code_pos`, `code_len` and `code_char` must stay stable; `char_ready` stays 0.
   - The stream must be identical to test 2.
6. **Reset mid-stream.** Assert `reset` during SEARCH of the second token.
   - All outputs return to their reset values.
   - Re-streaming "AAAA$" reproduces the test 1 output.
   - Cross-check every test by feeding the tokens to the decoder, which must output the original string.
